mp_addsub: RTL and testbench

Word-serial, parametrised multi-precision adder/subtractor for the long-integer datapath. It is the generalised successor of the fixed 513-bit start/done adder. Width and digit size are parameters, so area can be traded for latency by processing one WORD-bit digit per cycle with a registered carry. It sits between the operand registers and the Montgomery/exponentiation controllers, and keeps the same start/subtract/result/done contract.

---
 rtl/ddp_arith_pkg.sv | 19 +
 rtl/word_addsub.sv | 15 +
 rtl/mp_addsub.sv | 129 ++++++++++++
 tb/tb_mp_addsub.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddp_arith_pkg.sv
// Shared definitions for the long-integer datapath.
// Holds the sequencer state encoding and the helpers that size digit counters.
package ddp_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int cnt_width(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/word_addsub.sv
// Combinational WORD-bit digit adder.
// The top level supplies b_eff already inverted when it is subtracting.
module word_addsub #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b_eff,
  input  logic            cin,
  output logic [WORD-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WORD{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub.sv
// Word-serial multi-precision adder/subtractor: one WORD-bit digit per cycle,
// LSB digit first, with a registered inter-digit carry.
module mp_addsub
  import ddp_arith_pkg::*;
#(
  parameter int WIDTH = 513,
  parameter int WORD  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int NDIG  = ceil_div(WIDTH, WORD);
  localparam int PW    = NDIG * WORD;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WORD-1:0]  dig_sum;
  logic             dig_cout;
  logic [PW-1:0]    sum_shift;

  word_addsub #(.WORD(WORD)) u_digit (
    .a     (a_q[WORD-1:0]),
    .b_eff (b_q[WORD-1:0]),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout)
  );

  assign sum_shift = PW'({dig_sum, sum_q} >> WORD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction runs as A + ~B + 1; padding bits of B are inverted too.
          a_d     = PW'(in_a);
          b_d     = subtract ? ~PW'(in_b) : PW'(in_b);
          carry_d = subtract;
          sub_d   = subtract;
          cnt_d   = '0;
          state_d = ST_CALC;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_CALC: begin
        a_d     = a_q >> WORD;
        b_d     = b_q >> WORD;
        carry_d = dig_cout;
        sum_d   = sum_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // A + ~B + 1 over PW bits carries an extra 2^PW; flipping the
          // final carry removes it, making bit WIDTH the borrow.
          result_d = (WIDTH + 1)'({dig_cout ^ sub_q, sum_shift});
          state_d  = ST_DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mp_addsub.sv
// Bench for mp_addsub: directed table and handshake corner cases on the default
// configuration, plus a randomized sweep over three other WIDTH/WORD choices.
module tb_mp_addsub;

  logic         clk;
  logic         resetn;

  logic         start0, sub0;
  logic [512:0] a0, b0;
  logic [513:0] res0;
  logic         done0, busy0;

  logic         st_s, sub_s;
  logic [512:0] a_s, b_s;
  logic [513:0] r1, r2;
  logic [8:0]   r3;
  logic         d1, d2, d3, bz1, bz2, bz3;

  int checks = 0;
  int errors = 0;

  mp_addsub #(.WIDTH(513), .WORD(64)) u0 (
    .clk(clk), .resetn(resetn), .start(start0), .subtract(sub0),
    .in_a(a0), .in_b(b0), .result(res0), .done(done0), .busy(busy0));

  mp_addsub #(.WIDTH(513), .WORD(7)) u1 (
    .clk(clk), .resetn(resetn), .start(st_s), .subtract(sub_s),
    .in_a(a_s), .in_b(b_s), .result(r1), .done(d1), .busy(bz1));

  mp_addsub #(.WIDTH(513), .WORD(513)) u2 (
    .clk(clk), .resetn(resetn), .start(st_s), .subtract(sub_s),
    .in_a(a_s), .in_b(b_s), .result(r2), .done(d2), .busy(bz2));

  mp_addsub #(.WIDTH(8), .WORD(3)) u3 (
    .clk(clk), .resetn(resetn), .start(st_s), .subtract(sub_s),
    .in_a(a_s[7:0]), .in_b(b_s[7:0]), .result(r3), .done(d3), .busy(bz3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         sub;
    logic [512:0] a;
    logic [512:0] b;
    logic [513:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [513:0] act, input logic [513:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [512:0] a, input logic [512:0] b,
                              input logic [513:0] e, input string nm);
    vec_t v;
    v.sub = s; v.a = a; v.b = b; v.exp = e; v.name = nm;
    return v;
  endfunction

  function automatic logic [512:0] rnd513();
    logic [512:0] v;
    v = '0;
    for (int k = 0; k < 17; k++) v = (v << 32) | 513'($urandom());
    return v;
  endfunction

  // Called just after the accepting edge; returns edges counted until done.
  task automatic wait_done0(output int n);
    n = 0;
    while (!done0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run0(input logic s, input logic [512:0] a, input logic [512:0] b,
                      input logic [513:0] exp, input string nm);
    int n;
    @(negedge clk);
    start0 = 1'b1; sub0 = s; a0 = a; b0 = b;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk({nm, " busy"}, 514'(busy0), 514'(1));
    wait_done0(n);
    chk({nm, " done seen"}, 514'(done0), 514'(1));
    chk({nm, " latency"}, 514'(n), 514'(9));
    chk(nm, res0, exp);
    @(posedge clk); #1;
    chk({nm, " done width"}, 514'(done0), 514'(0));
    chk({nm, " hold"}, res0, exp);
  endtask

  task automatic run_sweep(input int idx);
    int n1, n2, n3;
    logic [513:0] e1;
    logic [8:0]   e3;
    @(negedge clk);
    st_s = 1'b1;
    @(posedge clk); #1;
    st_s = 1'b0;
    fork
      begin n1 = 0; while (!d1 && n1 < 100) begin @(posedge clk); #1; n1++; end end
      begin n2 = 0; while (!d2 && n2 < 100) begin @(posedge clk); #1; n2++; end end
      begin n3 = 0; while (!d3 && n3 < 100) begin @(posedge clk); #1; n3++; end end
    join
    e1 = sub_s ? ({1'b0, a_s} - {1'b0, b_s}) : ({1'b0, a_s} + {1'b0, b_s});
    e3 = sub_s ? ({1'b0, a_s[7:0]} - {1'b0, b_s[7:0]}) : ({1'b0, a_s[7:0]} + {1'b0, b_s[7:0]});
    chk($sformatf("w7 #%0d latency", idx), 514'(n1), 514'(74));
    chk($sformatf("w513 #%0d latency", idx), 514'(n2), 514'(1));
    chk($sformatf("w8x3 #%0d latency", idx), 514'(n3), 514'(3));
    chk($sformatf("w7 #%0d result", idx), r1, e1);
    chk($sformatf("w513 #%0d result", idx), r2, e1);
    chk($sformatf("w8x3 #%0d result", idx), 514'(r3), 514'(e3));
  endtask

  initial begin
    int n, seen;
    logic [512:0] ones;
    ones   = '1;
    resetn = 1'b0;
    start0 = 1'b0; sub0 = 1'b0; a0 = '0; b0 = '0;
    st_s   = 1'b0; sub_s = 1'b0; a_s = '0; b_s = '0;

    tbl[0] = mk(1'b1, ones, ones, 514'(0), "sub equal ones");
    tbl[1] = mk(1'b0, ones, ones, {{513{1'b1}}, 1'b0}, "add full carry");
    tbl[2] = mk(1'b0, 513'({64{1'b1}}), 513'(1), 514'(1) << 64, "add digit carry");
    tbl[3] = mk(1'b1, 513'(0), 513'(1), {514{1'b1}}, "sub 0-1");
    tbl[4] = mk(1'b1, 513'(5), 513'(3), 514'(2), "sub 5-3");
    tbl[5] = mk(1'b0, 513'(0), 513'(0), 514'(0), "add zeros");
    tbl[6] = mk(1'b1, 513'(1), 513'(0), 514'(1), "sub 1-0");
    tbl[7] = mk(1'b0, 513'(1) << 512, 513'(1) << 512, 514'(1) << 513, "add top bits");

    repeat (3) @(posedge clk);
    #1;
    chk("reset result", res0, 514'(0));
    chk("reset done", 514'(done0), 514'(0));
    chk("reset busy", 514'(busy0), 514'(0));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run0(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

    // start held through CALC with other operands must be ignored
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 513'(100); b0 = 513'(23);
    @(posedge clk); #1;
    sub0 = 1'b1; a0 = 513'(7); b0 = 513'(9000);
    repeat (5) begin @(posedge clk); #1; end
    start0 = 1'b0;
    n = 5;
    while (!done0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("held start latency", 514'(n), 514'(9));
    chk("held start result", res0, 514'(123));

    // back-to-back: start in the done cycle
    run0(1'b0, 513'(10), 513'(20), 514'(30), "b2b first");
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b1; a0 = 513'(50); b0 = 513'(8);
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0(n);
    chk("b2b first done", 514'(done0), 514'(1));
    chk("b2b first result", res0, 514'(42));
    sub0 = 1'b0; a0 = 513'(1000); b0 = 513'(24);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("b2b accepted busy", 514'(busy0), 514'(1));
    wait_done0(n);
    chk("b2b second latency", 514'(n), 514'(9));
    chk("b2b second result", res0, 514'(1024));
    @(posedge clk); #1;
    chk("b2b done width", 514'(done0), 514'(0));

    // reset in the middle of a computation
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 513'(3); b0 = 513'(4);
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset result", res0, 514'(0));
    chk("midreset busy", 514'(busy0), 514'(0));
    chk("midreset done", 514'(done0), 514'(0));
    resetn = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done0) seen++; end
    chk("midreset no done", 514'(seen), 514'(0));
    run0(1'b1, 513'(77), 513'(7), 514'(70), "after reset");

    // reset and start together: reset wins
    @(negedge clk);
    resetn = 1'b0; start0 = 1'b1; a0 = 513'(1); b0 = 513'(1);
    @(posedge clk); #1;
    chk("reset+start busy", 514'(busy0), 514'(0));
    start0 = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done0) seen++; end
    chk("reset+start no done", 514'(seen), 514'(0));

    // randomized parameter sweep against plain-arithmetic reference
    for (int i = 0; i < 300; i++) begin
      sub_s = 1'($urandom());
      a_s = rnd513();
      b_s = rnd513();
      case (i % 8)
        0: b_s = a_s;
        1: a_s = '0;
        2: a_s = '1;
        3: b_s = '1;
        default: ;
      endcase
      run_sweep(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
